// File: rtl/btn_debounce3.sv
// btn_debounce3: three independent push-button debouncers, each a 4-state FSM with a 2^N-cycle window.
// Define BTN_DEBOUNCE3_SYNC_EN to put a two-flop synchroniser in front of each channel.
module btn_debounce3 #(
    parameter int N = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn,
    output logic [2:0] db_level,
    output logic [2:0] db_tick
);
    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;
    logic [2:0] fin;
`ifdef BTN_DEBOUNCE3_SYNC_EN
    logic [2:0] sync_a, sync_b;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
        end
    end
    assign fin = sync_b;
`else
    assign fin = btn;
`endif
    genvar c;
    generate
        for (c = 0; c < 3; c++) begin : g_ch
            state_t       state;
            logic [N-1:0] cnt;
            logic         level, tick;
            // Level and tick only change on a completed window, so bounce aborts are silent.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state <= ZERO;
                    cnt   <= '0;
                    level <= 1'b0;
                    tick  <= 1'b0;
                end else begin
                    tick <= 1'b0;
                    case (state)
                        ZERO: if (fin[c]) begin
                            state <= WAIT1;
                            cnt   <= '0;
                        end
                        WAIT1: if (!fin[c]) state <= ZERO;
                        else if (cnt == '1) begin
                            state <= ONE;
                            level <= 1'b1;
                            tick  <= 1'b1;
                        end else cnt <= cnt + 1'b1;
                        ONE: if (!fin[c]) begin
                            state <= WAIT0;
                            cnt   <= '0;
                        end
                        WAIT0: if (fin[c]) state <= ONE;
                        else if (cnt == '1) begin
                            state <= ZERO;
                            level <= 1'b0;
                        end else cnt <= cnt + 1'b1;
                    endcase
                end
            end
            assign db_level[c] = level;
            assign db_tick[c]  = tick;
        end
    endgenerate
endmodule

// File: tb/tb_btn_debounce3.sv
// tb_btn_debounce3: scoreboard bench; expected output changes are queued when stimulus is driven.
module tb_btn_debounce3;
    localparam int N = 4;
`ifdef BTN_DEBOUNCE3_SYNC_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 16;
`endif
    localparam int SYN = LAT - 16;
    typedef struct {
        int         at;
        logic [2:0] mask;
        logic [2:0] val;
        logic [2:0] tick;
    } ev_t;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] btn = 3'b000;
    logic [2:0] db_level, db_tick;
    ev_t        sb[$];
    int         now = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [2:0] lv_e = 3'b000;
    logic [2:0] tk_e = 3'b000;

    btn_debounce3 #(.N(N)) dut (
        .clk(clk), .reset(reset), .btn(btn), .db_level(db_level), .db_tick(db_tick)
    );

    always #5 clk = ~clk;

    task automatic push(input int at, input logic [2:0] mask, input logic [2:0] val, input logic [2:0] tick);
        ev_t e;
        e.at = at; e.mask = mask; e.val = val; e.tick = tick;
        sb.push_back(e);
    endtask

    // Advance to the next sampling point and retire every scoreboard event due by now.
    task automatic step();
        @(negedge clk);
        now++;
        tk_e = 3'b000;
        while (sb.size() > 0 && sb[0].at <= now) begin
            lv_e = (lv_e & ~sb[0].mask) | (sb[0].val & sb[0].mask);
            tk_e = sb[0].tick;
            void'(sb.pop_front());
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (db_level !== 3'b000 || db_tick !== 3'b000) begin
                miscompares++;
                $display("FAIL reset t=%0d level=%b tick=%b want 000 000", now, db_level, db_tick);
            end
            if (i == 3) reset = 1'b0;
        end
    endtask

    task automatic test_clean_press();
        for (int i = 0; i < 45; i++) begin
            step();
            vectors++;
            if (db_level !== lv_e || db_tick !== tk_e) begin
                miscompares++;
                $display("FAIL clean_press t=%0d level=%b tick=%b want %b %b", now, db_level, db_tick, lv_e, tk_e);
            end
            if (i == 0) begin
                btn[1] = 1'b1;
                push(now + 1 + LAT, 3'b010, 3'b010, 3'b010);
            end
        end
    endtask

    task automatic test_release();
        for (int i = 0; i < 25; i++) begin
            step();
            vectors++;
            if (db_level !== lv_e || db_tick !== tk_e) begin
                miscompares++;
                $display("FAIL release t=%0d level=%b tick=%b want %b %b", now, db_level, db_tick, lv_e, tk_e);
            end
            if (i == 0) begin
                btn[1] = 1'b0;
                push(now + 1 + LAT, 3'b010, 3'b000, 3'b000);
            end
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 43 + LAT + 4; i++) begin
            step();
            vectors++;
            if (db_level !== lv_e || db_tick !== tk_e) begin
                miscompares++;
                $display("FAIL bounce t=%0d level=%b tick=%b want %b %b", now, db_level, db_tick, lv_e, tk_e);
            end
            btn[2] = (i < 10) || (i >= 13 && i < 43);
            if (i == 13) push(now + 1 + LAT, 3'b100, 3'b100, 3'b100);
            if (i == 43) push(now + 1 + LAT, 3'b100, 3'b000, 3'b000);
        end
    endtask

    task automatic test_final_edge();
        for (int i = 0; i < 50 + LAT + 4; i++) begin
            step();
            vectors++;
            if (db_level !== lv_e || db_tick !== tk_e) begin
                miscompares++;
                $display("FAIL final_edge t=%0d level=%b tick=%b want %b %b", now, db_level, db_tick, lv_e, tk_e);
            end
            btn[0] = (i < 16) || (i >= 18 && i < 50);
            if (i == 18) push(now + 1 + LAT, 3'b001, 3'b001, 3'b001);
            if (i == 50) push(now + 1 + LAT, 3'b001, 3'b000, 3'b000);
        end
    endtask

    task automatic test_reset_mid();
        int r;
        r = 11 + SYN + LAT + 5;
        for (int i = 0; i < r + LAT + 4; i++) begin
            step();
            vectors++;
            if (db_level !== lv_e || db_tick !== tk_e) begin
                miscompares++;
                $display("FAIL reset_mid t=%0d level=%b tick=%b want %b %b", now, db_level, db_tick, lv_e, tk_e);
            end
            if (i == 0) begin
                btn[0] = 1'b1;
                push(now + 1 + LAT, 3'b001, 3'b001, 3'b001);
            end
            if (i == 10 + SYN) begin
                reset = 1'b1;
                sb.delete();
                push(now + 1, 3'b111, 3'b000, 3'b000);
            end
            if (i == 11 + SYN) begin
                reset = 1'b0;
                push(now + 1 + LAT, 3'b001, 3'b001, 3'b001);
            end
            if (i == r) begin
                btn[0] = 1'b0;
                push(now + 1 + LAT, 3'b001, 3'b000, 3'b000);
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 30 + LAT + 4; i++) begin
            step();
            vectors++;
            if (db_level !== lv_e || db_tick !== tk_e) begin
                miscompares++;
                $display("FAIL simultaneous t=%0d level=%b tick=%b want %b %b", now, db_level, db_tick, lv_e, tk_e);
            end
            if (i == 0) begin
                btn = 3'b111;
                push(now + 1 + LAT, 3'b111, 3'b111, 3'b111);
            end
            if (i == 30) begin
                btn = 3'b000;
                push(now + 1 + LAT, 3'b111, 3'b000, 3'b000);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_final_edge();
        test_reset_mid();
        test_simultaneous();
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain pending=%0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
